// File: rtl/edge_capture_ctrl.sv
// Sticky per-channel edge capture with W1C clear, overflow tracking and a
// masked, registered interrupt. Optional input synchroniser for async pins.
module edge_capture_ctrl #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [2*WIDTH-1:0] mode_i,
    input  logic [WIDTH-1:0]   irq_en_i,
    input  logic               clr_i,
    input  logic [WIDTH-1:0]   clr_mask_i,
    output logic [WIDTH-1:0]   edge_o,
    output logic [WIDTH-1:0]   ovf_o,
    output logic               irq_o
);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] clr;
    logic             prime;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = data_i;
        end else begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= '0;
                    end
                end else begin
                    sync_q[0] <= data_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign rise = ~data_q & s;
    assign fall = data_q & ~s;
    assign clr  = {WIDTH{clr_i}} & clr_mask_i;

    // Mode bit 0 enables rise, bit 1 enables fall; 11 therefore gives both.
    always_comb begin
        hit = '0;
        for (int k = 0; k < WIDTH; k++) begin
            hit[k] = (mode_i[2*k] & rise[k]) | (mode_i[2*k+1] & fall[k]);
        end
    end

    // The prime cycle loads data_q from the live inputs so levels already
    // high at reset release are not reported as rising edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            edge_o <= '0;
            ovf_o  <= '0;
            irq_o  <= 1'b0;
            prime  <= 1'b1;
        end else if (prime) begin
            data_q <= s;
            prime  <= 1'b0;
            irq_o  <= |(edge_o & irq_en_i);
        end else begin
            data_q <= s;
            edge_o <= hit | (edge_o & ~clr);
            ovf_o  <= (hit & edge_o & ~clr) | (ovf_o & ~clr);
            irq_o  <= |(edge_o & irq_en_i);
        end
    end

endmodule

// File: tb/tb_edge_capture_ctrl.sv
// Directed bench for edge_capture_ctrl: a vector table on a 32-channel
// instance plus hand sequences for prime and the 2-stage synchroniser.
module tb_edge_capture_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] data;
    logic [63:0] mode;
    logic [31:0] irq_en;
    logic        clr;
    logic [31:0] clr_mask;
    logic [31:0] edge_q;
    logic [31:0] ovf_q;
    logic        irq;

    logic        reset1;
    logic [3:0]  data1;
    logic [7:0]  mode1;
    logic [3:0]  irq_en1;
    logic        clr1;
    logic [3:0]  clr_mask1;
    logic [3:0]  edge1;
    logic [3:0]  ovf1;
    logic        irq1;

    int n_vec  = 0;
    int n_fail = 0;

    edge_capture_ctrl #(.WIDTH(32), .SYNC_STAGES(0)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .data_i     (data),
        .mode_i     (mode),
        .irq_en_i   (irq_en),
        .clr_i      (clr),
        .clr_mask_i (clr_mask),
        .edge_o     (edge_q),
        .ovf_o      (ovf_q),
        .irq_o      (irq)
    );

    edge_capture_ctrl #(.WIDTH(4), .SYNC_STAGES(2)) u_dut_sync (
        .clk        (clk),
        .reset      (reset1),
        .data_i     (data1),
        .mode_i     (mode1),
        .irq_en_i   (irq_en1),
        .clr_i      (clr1),
        .clr_mask_i (clr_mask1),
        .edge_o     (edge1),
        .ovf_o      (ovf1),
        .irq_o      (irq1)
    );

    typedef struct {
        logic        rst;
        logic [31:0] data;
        logic [63:0] mode;
        logic [31:0] en;
        logic        clr;
        logic [31:0] mask;
        logic [31:0] exp_edge;
        logic [31:0] exp_ovf;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[$];

    localparam logic [63:0] M = 64'h0000_0000_0004_4439;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [31:0] d, input logic [63:0] m,
                       input logic [31:0] e, input logic c, input logic [31:0] k,
                       input logic [31:0] xe, input logic [31:0] xo, input logic xi);
        vec_t v;
        v.rst = r; v.data = d; v.mode = m; v.en = e; v.clr = c; v.mask = k;
        v.exp_edge = xe; v.exp_ovf = xo; v.exp_irq = xi;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1; data = 32'hFFFF_FFFF; mode = {32{2'b01}};
        irq_en = '0; clr = 1'b0; clr_mask = '0;
        reset1 = 1'b1; data1 = '0; mode1 = 8'h01; irq_en1 = 4'h1;
        clr1 = 1'b0; clr_mask1 = '0;

        //  rst data          mode               en         clr mask          edge   ovf    irq
        add(1, 32'h0,   M,                 32'h0,   0, 32'h0,        32'h0,   32'h0,   0); // 0 reset
        add(0, 32'h0,   M,                 32'h0,   0, 32'h0,        32'h0,   32'h0,   0); // 1 prime
        add(0, 32'hF,   M,                 32'h0,   0, 32'h0,        32'h5,   32'h0,   0); // 2 rise
        add(0, 32'h0,   M,                 32'h0,   0, 32'h0,        32'h7,   32'h4,   0); // 3 fall
        add(0, 32'h0,   M,                 32'h0,   0, 32'h0,        32'h7,   32'h4,   0); // 4 hold
        add(0, 32'h0,   M,                 32'h0,   1, 32'hF,        32'h0,   32'h0,   0); // 5 clear
        add(0, 32'h20,  M,                 32'h0,   0, 32'h0,        32'h20,  32'h0,   0); // 6 ch5 rise
        add(0, 32'h0,   M,                 32'h0,   0, 32'h0,        32'h20,  32'h0,   0); // 7
        add(0, 32'h20,  M,                 32'h0,   0, 32'h0,        32'h20,  32'h20,  0); // 8 re-hit
        add(0, 32'h0,   M,                 32'h0,   1, 32'h20,       32'h0,   32'h0,   0); // 9 clear ch5
        add(0, 32'h20,  M,                 32'h0,   0, 32'h0,        32'h20,  32'h0,   0); // 10
        add(0, 32'h20,  M,                 32'h0,   0, 32'hFFFF_FFFF, 32'h20, 32'h0,   0); // 11 mask w/o clr
        add(0, 32'h0,   M,                 32'h0,   1, 32'h20,       32'h0,   32'h0,   0); // 12
        add(0, 32'h80,  M,                 32'h0,   0, 32'h0,        32'h80,  32'h0,   0); // 13 ch7
        add(0, 32'h0,   M,                 32'h0,   0, 32'h0,        32'h80,  32'h0,   0); // 14
        add(0, 32'h80,  M,                 32'h0,   0, 32'h0,        32'h80,  32'h80,  0); // 15 ovf
        add(0, 32'h0,   M,                 32'h0,   0, 32'h0,        32'h80,  32'h80,  0); // 16
        add(0, 32'h80,  M,                 32'h0,   1, 32'h80,       32'h80,  32'h0,   0); // 17 hit+clr
        add(0, 32'h80,  M,                 32'h0,   1, 32'h100,      32'h80,  32'h0,   0); // 18 clr unset bit
        add(0, 32'h80,  M,                 32'h0,   1, 32'h80,       32'h0,   32'h0,   0); // 19
        add(0, 32'h200, M,                 32'h0,   0, 32'h0,        32'h200, 32'h0,   0); // 20 ch9
        add(0, 32'h200, M,                 32'h0,   0, 32'h0,        32'h200, 32'h0,   0); // 21 en off
        add(0, 32'h200, M,                 32'h200, 0, 32'h0,        32'h200, 32'h0,   1); // 22 en on
        add(0, 32'h200, M,                 32'h200, 1, 32'h200,      32'h0,   32'h0,   1); // 23 clr
        add(0, 32'h200, M,                 32'h200, 0, 32'h0,        32'h0,   32'h0,   0); // 24 irq drops
        add(0, 32'h8,   M,                 32'h0,   0, 32'h0,        32'h0,   32'h0,   0); // 25 ch3 off
        add(0, 32'h8,   M | 64'h40,        32'h0,   0, 32'h0,        32'h0,   32'h0,   0); // 26 ch3 on
        add(0, 32'h0,   M,                 32'h0,   0, 32'h0,        32'h0,   32'h0,   0); // 27
        add(0, 32'h1,   M,                 32'h0,   0, 32'h0,        32'h1,   32'h0,   0); // 28
        add(1, 32'h1,   M,                 32'h0,   0, 32'h0,        32'h0,   32'h0,   0); // 29 reset
        add(0, 32'h1,   M,                 32'h0,   0, 32'h0,        32'h0,   32'h0,   0); // 30 prime
        add(0, 32'h1,   M,                 32'h0,   0, 32'h0,        32'h0,   32'h0,   0); // 31

        // Inputs already high through reset must not look like rises.
        step();
        step();
        chk("t1 reset edge", edge_q, 32'h0);
        chk("t1 reset irq", {31'd0, irq}, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("t1 prime edge c%0d", i), edge_q, 32'h0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; data = tbl[i].data; mode = tbl[i].mode;
            irq_en = tbl[i].en; clr = tbl[i].clr; clr_mask = tbl[i].mask;
            step();
            chk($sformatf("row%0d edge", i), edge_q, tbl[i].exp_edge);
            chk($sformatf("row%0d ovf", i), ovf_q, tbl[i].exp_ovf);
            chk($sformatf("row%0d irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
        end

        // Two-stage synchroniser: rise visible on the third clock.
        reset1 = 1'b0;
        step();
        step();
        data1 = 4'h1;
        step();
        chk("t6 sync c1", {28'd0, edge1}, 32'h0);
        step();
        chk("t6 sync c2", {28'd0, edge1}, 32'h0);
        step();
        chk("t6 sync c3", {28'd0, edge1}, 32'h1);
        chk("t6 sync c3 irq", {31'd0, irq1}, 32'h0);
        step();
        chk("t6 sync c4 irq", {31'd0, irq1}, 32'h1);
        reset1 = 1'b1;
        step();
        chk("t6 rst edge", {28'd0, edge1}, 32'h0);
        chk("t6 rst ovf", {28'd0, ovf1}, 32'h0);
        chk("t6 rst irq", {31'd0, irq1}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
